fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage plus IF/ID pipeline register for the 5-stage mips core; sits directly upstream of the decode stage.
- Owns the PC register and drives the instruction_memory word address.
- Selects the next PC from sequential, branch or jump sources.
- Honours stall/flush from the hazard logic; never loses a redirect that arrives during a stall.

---
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with PC register, redirect handling and IF/ID pipeline register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallF,
    input  logic               flushD,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pcF,
    output logic [31:0]        instructionD,
    output logic [31:0]        pc_4D,
    output logic               validD,
    output logic               misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stalls
`endif
);
    logic        redir;
    logic [31:0] raw_tgt;
    logic [31:0] tgt;
    logic [31:0] pc_next;
    logic [31:0] pend_pc;
    logic        pend_v;

    assign redir     = branch_taken | jump;
    assign raw_tgt   = branch_taken ? branch_target : jump_target;
    assign tgt       = {raw_tgt[31:2], 2'b00};
    assign imem_addr = pcF[IMEM_AW+1:2];

    always_comb begin
        pc_next = pcF + 32'd4;
        if (stallF)
            pc_next = pcF;
        else if (redir)
            pc_next = tgt;
        else if (pend_v)
            pc_next = pend_pc;
    end

    // A redirect seen while stalled is parked until the stall releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcF          <= RESET_PC;
            pend_pc      <= 32'h0;
            pend_v       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            pcF <= pc_next;
            if (stallF && redir) begin
                pend_pc <= tgt;
                pend_v  <= 1'b1;
            end else if (!stallF) begin
                pend_v  <= 1'b0;
            end
            if (redir && raw_tgt[1:0] != 2'b00)
                misalign_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instructionD <= 32'h0;
            pc_4D        <= 32'h0;
            validD       <= 1'b0;
        end else if (flushD) begin
            instructionD <= 32'h0;
            pc_4D        <= 32'h0;
            validD       <= 1'b0;
        end else if (!stallF) begin
            instructionD <= imem_rdata;
            pc_4D        <= pcF + 32'd4;
            validD       <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= 32'h0;
            perf_stalls  <= 32'h0;
        end else begin
            if (!stallF && !flushD)
                perf_fetched <= perf_fetched + 32'd1;
            if (stallF)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage; imem returns the word index as data.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallF = 1'b0, flushD = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic [31:0] branch_target = 32'h0, jump_target = 32'h0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata, pcF, instructionD, pc_4D;
    logic        validD, misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalls;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
        logic        v;
        logic        me;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    assign imem_rdata = {22'h0, imem_addr};

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stallF(stallF), .flushD(flushD),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pcF(pcF), .instructionD(instructionD), .pc_4D(pc_4D),
        .validD(validD), .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
`endif
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ins,
                                input logic [31:0] pc4, input logic v, input logic me);
        mk = '{pc, ins, pc4, v, me};
    endfunction

    function automatic exp_t obs();
        obs = '{pcF, instructionD, pc_4D, validD, misalign_err};
    endfunction

    task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        stallF = s; flushD = f; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, got;
        #3;
        exp_q.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        e = exp_q.pop_front(); got = obs();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset got %h exp %h", got, e);
        end
`ifdef FETCH_PERF_EN
        vectors++;
        if (perf_fetched !== 32'h0 || perf_stalls !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_perf got %h/%h exp 0/0", perf_fetched, perf_stalls);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_seq();
        exp_t e, got;
        for (int i = 1; i <= 2; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            exp_q.push_back(mk(32'(4 * i), 32'(i - 1), 32'(4 * i), 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front(); got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL seq[%0d] got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e, got;
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, 0, 0, 0, 0, 0);
            exp_q.push_back(i < 3 ? mk(32'h8, 32'h1, 32'h8, 1'b1, 1'b0) :
                            i == 3 ? mk(32'hC, 32'h2, 32'hC, 1'b1, 1'b0) :
                                     mk(32'h10, 32'h3, 32'h10, 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front(); got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL stall[%0d] got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e, got;
        for (int i = 0; i < 2; i++) begin
            drive(0, i == 0, i == 0, 32'h40, 0, 0);
            exp_q.push_back(i == 0 ? mk(32'h40, 32'h0, 32'h0, 1'b0, 1'b0) :
                                     mk(32'h44, 32'h10, 32'h44, 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front(); got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL branch[%0d] got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_pending();
        exp_t e, got;
        for (int i = 0; i < 4; i++) begin
            drive(i < 2, i == 2, 0, 0, i == 0, 32'h80);
            exp_q.push_back(i < 2  ? mk(32'h44, 32'h10, 32'h44, 1'b1, 1'b0) :
                            i == 2 ? mk(32'h80, 32'h0, 32'h0, 1'b0, 1'b0) :
                                     mk(32'h84, 32'h20, 32'h84, 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front(); got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL pending[%0d] got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_both_misalign();
        exp_t e, got;
        for (int i = 0; i < 3; i++) begin
            drive(0, i < 2, i < 2, i == 0 ? 32'h100 : 32'h103, i == 0, 32'h200);
            exp_q.push_back(i == 0 ? mk(32'h100, 32'h0, 32'h0, 1'b0, 1'b0) :
                            i == 1 ? mk(32'h100, 32'h0, 32'h0, 1'b0, 1'b1) :
                                     mk(32'h104, 32'h40, 32'h104, 1'b1, 1'b1));
            tick();
            e = exp_q.pop_front(); got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL both_misalign[%0d] got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e, got;
        drive(0, 1, 1, 32'h40, 0, 0);
        exp_q.push_back(mk(32'h40, 32'h0, 32'h0, 1'b0, 1'b1));
        tick();
        drive(1, 0, 0, 0, 1, 32'h200);
        exp_q.push_back(mk(32'h40, 32'h0, 32'h0, 1'b0, 1'b1));
        tick();
        exp_q.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h4, 32'h0, 32'h4, 1'b1, 1'b0));
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front(); got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL async_setup[%0d] got %h exp %h", i, got, e);
            end
            if (i == 0) tick();
        end
        #1 rst = 1'b1;
        #1;
        e = exp_q.pop_front(); got = obs();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL async_rst got %h exp %h", got, e);
        end
        drive(0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        tick();
        e = exp_q.pop_front(); got = obs();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL after_rst got %h exp %h", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_stall();
        test_branch();
        test_pending();
        test_both_misalign();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
